// File: rtl/oc8051_fetch_queue.sv
// Instruction-fetch byte queue: issues 4-byte code ROM fetches, buffers the bytes
// in a circular queue and presents the next three instruction bytes at the PC.
module oc8051_fetch_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    output logic          rom_req,
    output logic [AW-1:0] rom_addr,
    input  logic          rom_ack,
    input  logic [31:0]   rom_data,
    input  logic          jmp_valid,
    input  logic [AW-1:0] jmp_addr,
    input  logic [1:0]    consume,
    output logic [AW-1:0] pc_out,
    output logic [1:0]    ops_avail,
    output logic [7:0]    op0_out,
    output logic [7:0]    op1_out,
    output logic [7:0]    op2_out
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   fptr_q, fptr_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic            rom_req_q, rom_req_d;
    logic [AW-1:0]   rom_addr_q, rom_addr_d;
    logic [1:0]      avail_q, avail_d;
    logic [7:0]      op_q [3];
    logic [7:0]      op_d [3];

    logic [CW-1:0]   cons_w;
    logic [CW-1:0]   cons_eff;
    logic [CW-1:0]   free_bytes;
    logic            push;

    always_comb begin
        state_d    = state_q;
        mem_d      = mem_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        fptr_d     = fptr_q;
        pc_d       = pc_q;
        rom_addr_d = rom_addr_q;

        cons_w     = CW'(consume);
        cons_eff   = (cons_w > count_q) ? count_q : cons_w;
        free_bytes = CW'(DEPTH) - count_q;
        push       = (state_q == REQ) && rom_ack;

        if (jmp_valid) begin
            // An outstanding fetch must still be acked; DROP swallows it.
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
            pc_d    = jmp_addr;
            fptr_d  = jmp_addr;
            if (state_q != IDLE) begin
                state_d = rom_ack ? IDLE : DROP;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (free_bytes >= CW'(4)) begin
                        state_d    = REQ;
                        rom_addr_d = fptr_q;
                    end
                end
                REQ:     if (rom_ack) state_d = IDLE;
                DROP:    if (rom_ack) state_d = IDLE;
                default: state_d = IDLE;
            endcase

            if (push) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    mem_d[tail_q + PW'(i)] = rom_data[8*i +: 8];
                end
                tail_d = tail_q + PW'(4);
                fptr_d = fptr_q + AW'(4);
            end

            head_d  = head_q + cons_eff[PW-1:0];
            pc_d    = pc_q + AW'(cons_eff);
            count_d = count_q + (push ? CW'(4) : CW'(0)) - cons_eff;
        end

        rom_req_d = (state_d != IDLE);
        avail_d   = (count_d >= CW'(3)) ? 2'd3 : count_d[1:0];
        for (int unsigned n = 0; n < 3; n++) begin
            op_d[n] = (CW'(n) < count_d) ? mem_d[head_d + PW'(n)] : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mem_q      <= '{default: '0};
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            fptr_q     <= '0;
            pc_q       <= '0;
            rom_req_q  <= 1'b0;
            rom_addr_q <= '0;
            avail_q    <= '0;
            op_q       <= '{default: '0};
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            fptr_q     <= fptr_d;
            pc_q       <= pc_d;
            rom_req_q  <= rom_req_d;
            rom_addr_q <= rom_addr_d;
            avail_q    <= avail_d;
            op_q       <= op_d;
        end
    end

    assign rom_req   = rom_req_q;
    assign rom_addr  = rom_addr_q;
    assign pc_out    = pc_q;
    assign ops_avail = avail_q;
    assign op0_out   = op_q[0];
    assign op1_out   = op_q[1];
    assign op2_out   = op_q[2];

endmodule

// File: tb/tb_oc8051_fetch_queue.sv
// Bench for oc8051_fetch_queue: directed stimulus with a byte-stream scoreboard
// checked by a monitor on every retired byte, plus hand-computed spot checks.
module tb_oc8051_fetch_queue;

    logic        clk;
    logic        rst;
    logic        rom_req;
    logic [15:0] rom_addr;
    logic        rom_ack;
    logic [31:0] rom_data;
    logic        jmp_valid;
    logic [15:0] jmp_addr;
    logic [1:0]  consume;
    logic [15:0] pc_out;
    logic [1:0]  ops_avail;
    logic [7:0]  op0_out, op1_out, op2_out;

    oc8051_fetch_queue #(.DEPTH(8), .AW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .rom_req   (rom_req),
        .rom_addr  (rom_addr),
        .rom_ack   (rom_ack),
        .rom_data  (rom_data),
        .jmp_valid (jmp_valid),
        .jmp_addr  (jmp_addr),
        .consume   (consume),
        .pc_out    (pc_out),
        .ops_avail (ops_avail),
        .op0_out   (op0_out),
        .op1_out   (op1_out),
        .op2_out   (op2_out)
    );

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } sb_t;

    sb_t         exp_q [$];
    int          checks   = 0;
    int          failures = 0;
    int          retired  = 0;
    int unsigned lat      = 0;
    int unsigned wcnt     = 0;
    bit          force_ack = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Code ROM contents: byte at address a is a[7:0]^a[15:8].
    function automatic logic [7:0] bf(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    function automatic logic [31:0] word_at(input logic [15:0] a);
        return {bf(a + 16'd3), bf(a + 16'd2), bf(a + 16'd1), bf(a)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic push_stream(input logic [15:0] start, input int n);
        sb_t e;
        for (int k = 0; k < n; k++) begin
            e.addr = start + 16'(k);
            e.data = bf(e.addr);
            exp_q.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // ROM with programmable ack latency (0 = ack in the first request cycle).
    always @(negedge clk) begin
        rom_ack = 1'b0;
        if (force_ack) begin
            rom_ack  = 1'b1;
            rom_data = word_at(rom_addr);
        end else if (rom_req && !rst) begin
            if (wcnt >= lat) begin
                rom_ack  = 1'b1;
                rom_data = word_at(rom_addr);
                wcnt     = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    logic [7:0]  m_ops [3];
    int unsigned m_n;
    sb_t         m_e;

    always @(negedge clk) begin
        if (!rst && !jmp_valid) begin
            m_ops[0] = op0_out;
            m_ops[1] = op1_out;
            m_ops[2] = op2_out;
            m_n = (consume > ops_avail) ? 32'(ops_avail) : 32'(consume);
            for (int i = 0; i < 3; i++) begin
                if (i < int'(m_n)) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_underflow got=retire@%h exp=none", pc_out + 16'(i));
                    end else begin
                        m_e = exp_q.pop_front();
                        chk("sb_byte", {8'h00, pc_out + 16'(i), m_ops[i]}, {8'h00, m_e.addr, m_e.data});
                        retired++;
                    end
                end else if (i >= int'(ops_avail)) begin
                    chk("op_pad", 32'(m_ops[i]), 32'h0);
                end
            end
        end
    end

    int  found;
    bit  dipped;

    initial begin
        rst = 1'b1; jmp_valid = 1'b0; jmp_addr = '0; consume = '0;
        rom_ack = 1'b0; rom_data = '0;
        repeat (3) step();
        chk("rst_req", 32'(rom_req), 32'h0);
        chk("rst_addr", 32'(rom_addr), 32'h0);
        chk("rst_pc", 32'(pc_out), 32'h0);
        chk("rst_avail", 32'(ops_avail), 32'h0);
        chk("rst_ops", {8'h00, op0_out, op1_out, op2_out}, 32'h0);

        // 1: zero-wait fill from reset
        exp_q.delete();
        push_stream(16'h0000, 80);
        rst = 1'b0;
        step();
        chk("t1_req", 32'(rom_req), 32'h1);
        chk("t1_addr", 32'(rom_addr), 32'h0);
        step();
        chk("t1_avail", 32'(ops_avail), 32'h3);
        chk("t1_pc", 32'(pc_out), 32'h0);
        chk("t1_ops", {8'h00, op0_out, op1_out, op2_out}, 32'h00000102);
        repeat (3) step();
        chk("t1_full_req", 32'(rom_req), 32'h0);
        chk("t1_last_addr", 32'(rom_addr), 32'h4);

        // 2: consume 3 per cycle against a slow ROM
        lat = 2; consume = 2'd3; dipped = 0;
        for (int c = 0; c < 16; c++) begin
            step();
            if (ops_avail < 2'd3) dipped = 1;
        end
        consume = 2'd0;
        chk("t2_dip", 32'(dipped), 32'h1);
        chk("t2_progress", 32'(retired >= 12), 32'h1);

        // 3: jump while a fetch is pending
        jmp_valid = 1'b1; jmp_addr = 16'h1000;
        exp_q.delete(); push_stream(16'h1000, 8);
        step();
        jmp_valid = 1'b0;
        chk("t3_jpc", 32'(pc_out), 32'h1000);
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            step();
            if (rom_req && rom_addr == 16'h1000) found = 1;
        end
        chk("t3_req1000", found, 1);
        jmp_valid = 1'b1; jmp_addr = 16'h1235;
        exp_q.delete(); push_stream(16'h1235, 40);
        step();
        jmp_valid = 1'b0;
        chk("t3_drop_req", 32'(rom_req), 32'h1);
        chk("t3_drop_addr", 32'(rom_addr), 32'h1000);
        chk("t3_drop_avail", 32'(ops_avail), 32'h0);
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            step();
            if (rom_req && rom_addr == 16'h1235) found = 1;
        end
        chk("t3_redirect", found, 1);
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            step();
            if (ops_avail != 2'd0) found = 1;
        end
        chk("t3_filled", found, 1);
        chk("t3_op0", {pc_out, 8'h00, op0_out}, {16'h1235, 8'h00, 8'h27});

        // 4: unaligned fetch wrapping through 0000
        lat = 0; consume = 2'd0;
        jmp_valid = 1'b1; jmp_addr = 16'hFFFE;
        exp_q.delete(); push_stream(16'hFFFE, 40);
        step();
        jmp_valid = 1'b0; consume = 2'd1;
        step();
        chk("t4_req", {15'h0, rom_req, rom_addr}, {15'h0, 1'b1, 16'hFFFE});
        step();
        chk("t4_pc0", 32'(pc_out), 32'hFFFE);
        chk("t4_ops", {8'h00, op0_out, op1_out, op2_out}, 32'h00010000);
        step();
        chk("t4_pc1", 32'(pc_out), 32'hFFFF);
        chk("t4_addr2", {15'h0, rom_req, rom_addr}, {15'h0, 1'b1, 16'h0002});
        step();
        chk("t4_pc2", 32'(pc_out), 32'h0000);
        consume = 2'd0;

        // 5: consume clamped to the single remaining byte
        lat = 5;
        jmp_valid = 1'b1; jmp_addr = 16'h2000;
        exp_q.delete(); push_stream(16'h2000, 16);
        step();
        jmp_valid = 1'b0;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            step();
            if (ops_avail == 2'd3) found = 1;
        end
        chk("t5_fill", found, 1);
        consume = 2'd3;
        step();
        chk("t5_one", {pc_out, 6'h0, ops_avail, op0_out}, {16'h2003, 6'h0, 2'd1, 8'h23});
        chk("t5_one_op1", 32'(op1_out), 32'h0);
        step();
        chk("t5_clamp", {pc_out, 6'h0, ops_avail, op0_out}, {16'h2004, 6'h0, 2'd0, 8'h00});
        consume = 2'd0;

        // 6: reset mid-request, late ack ignored
        chk("t6_pending", 32'(rom_req), 32'h1);
        rst = 1'b1;
        step();
        chk("t6_rst_req", {15'h0, rom_req, rom_addr}, 32'h0);
        chk("t6_rst_q", {pc_out, 6'h0, ops_avail, 8'h00}, 32'h0);
        chk("t6_rst_ops", {8'h00, op0_out, op1_out, op2_out}, 32'h0);
        rst = 1'b0; force_ack = 1;
        exp_q.delete(); push_stream(16'h0000, 40);
        step();
        force_ack = 0; lat = 0;
        chk("t6_ack_ignored", {pc_out, 6'h0, ops_avail, 8'h00}, 32'h0);
        chk("t6_new_req", {15'h0, rom_req, rom_addr}, {15'h0, 1'b1, 16'h0000});
        consume = 2'd2;
        repeat (10) step();
        consume = 2'd0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
